dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: the pipeline MEM stage (port P) and
//  the program/data loader (port L). Sequences each access through a fixed-latency memory, returns
//  read data with a valid pulse, and raises mem_stall so the pipeline freezes while its access is
//  pending. P has priority; a starvation counter guarantees L progress.
// PARAMETERS
//  ADDR_W      16  address width (word index into data memory)
//  DATA_W      32  data width
//  MEM_LAT     1   cycles from m_en to valid m_rdata (>=1)
//  STARVE_MAX  4   consecutive lost arbitrations after which L wins once (>=1)
// PORTS
//  clk       in   1       clock, all state on posedge
//  rst       in   1       asynchronous reset, active-high
//  p_req     in   1       MEM stage access request; hold with stable we/addr/wdata until p_gnt
//  p_we      in   1       1 = store, 0 = load
//  p_addr    in   ADDR_W  access address
//  p_wdata   in   DATA_W  store data
//  p_flush   in   1       squash pending P response (jump/branch flush)
//  p_gnt     out  1       one-cycle pulse: P request accepted
//  p_rvalid  out  1       one-cycle pulse: P access complete (load data or store ack)
//  p_rdata   out  DATA_W  load data, valid with p_rvalid; 0 for stores
//  mem_stall out  1       p_req & ~p_rvalid (combinational from registered p_rvalid)
//  l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata : loader port, same rules as P (no flush)
//  m_en      out  1       memory access strobe, exactly one cycle per access
//  m_we      out  1       memory write enable, qualified by m_en
//  m_addr    out  ADDR_W  memory address
//  m_wdata   out  DATA_W  memory write data
//  m_rdata   in   DATA_W  memory read data, valid MEM_LAT cycles after m_en cycle
// BEHAVIOUR
//  Reset: state IDLE, owner P, starve_cnt 0; all outputs 0 (mem_stall = p_req). rst mid-access
//   abandons it: no gnt/rvalid issued; a store already strobed on m_en stands.
//  FSM IDLE -> ISSUE -> WAIT(MEM_LAT cycles) -> RESP -> IDLE, or RESP -> ISSUE if a req is present.
//  Arbitration at the edge ending IDLE or RESP: winner latched as owner with its we/addr/wdata.
//   Both req: P wins unless starve_cnt==STARVE_MAX; only one req: it wins; none: go/stay IDLE.
//  starve_cnt: +1 when L requests and loses; cleared when L wins; saturates at STARVE_MAX.
//  ISSUE (1 cycle): m_en=1, m_we/m_addr/m_wdata from latch, owner's gnt=1.
//  WAIT: count MEM_LAT down; on last WAIT cycle register m_rdata (0 if store).
//  RESP (1 cycle): owner's rvalid=1, rdata=registered value; other port rvalid=0.
//  Latency: req sampled at edge E0 -> gnt in cycle 1, rvalid in cycle MEM_LAT+2. Throughput one
//   access per MEM_LAT+2 cycles under continuous demand.
//  p_flush while owner=P and state in ISSUE/WAIT/RESP: suppress p_rvalid of that access (load
//   discarded, store still performed); flush during IDLE has no effect. L accesses unaffected.
//  rdata outputs hold last value between pulses; gnt/rvalid never high for both ports same cycle.
//  Request withdrawn before gnt: legal, no access; req sampled only at arbitration edges.
// STRUCTURE
//  Package dmem_arb_pkg: state enum (IDLE/ISSUE/WAIT/RESP), owner encoding (OWN_P/OWN_L),
//   ADDR_W/DATA_W defaults.
//  Sub-module dmem_arb_pick: combinational winner select + starve_cnt register.
//  FSM, latency counter, request/response latches in top.
// TESTING
//  1 P load only, MEM_LAT=1, addr 0x0010 holds 0xDEADBEEF -> m_en cycle 1, p_rvalid cycle 3 with
//    0xDEADBEEF; mem_stall high cycles 0-2, low cycle 3.
//  2 P store 0x12345678 @0x0004 then P load @0x0004 back-to-back -> second m_en 3 cycles after
//    first, p_rdata 0x12345678.
//  3 P and L request every arbitration, STARVE_MAX=4 -> grant order P,P,P,P,L repeating;
//    starve_cnt returns to 0 after each L grant.
//  4 MEM_LAT=3, P load, p_flush in WAIT -> no p_rvalid; next P load completes normally at cycle 5.
//  5 rst asserted during WAIT of L load -> all outputs 0 immediately; after release, new P request
//    granted in cycle 1 with no stale l_rvalid.
//  6 L store 0xA5A5A5A5 @0xFFFF (top address) -> m_addr 0xFFFF, l_rvalid with l_rdata 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_L = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the MEM-stage port and the loader port, with a
// starvation counter that forces one loader win after STARVE_MAX losses.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_arb_en,
    input  logic   i_p_req,
    input  logic   i_l_req,
    output logic   o_win_valid,
    output owner_t o_win_owner
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        o_win_valid = i_p_req | i_l_req;
        o_win_owner = OWN_P;
        if (i_l_req && (!i_p_req || w_starved)) begin
            o_win_owner = OWN_L;
        end
    end

    // Counter only moves on arbitration edges where the loader is actually asking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (i_arb_en && i_l_req) begin
            if (o_win_owner == OWN_L) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port fixed-latency data memory:
// pipeline MEM stage (P, priority, flushable) and program/data loader (L).
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_p_req,
    input  logic              i_p_we,
    input  logic [ADDR_W-1:0] i_p_addr,
    input  logic [DATA_W-1:0] i_p_wdata,
    input  logic              i_p_flush,
    output logic              o_p_gnt,
    output logic              o_p_rvalid,
    output logic [DATA_W-1:0] o_p_rdata,
    output logic              o_mem_stall,
    input  logic              i_l_req,
    input  logic              i_l_we,
    input  logic [ADDR_W-1:0] i_l_addr,
    input  logic [DATA_W-1:0] i_l_wdata,
    output logic              o_l_gnt,
    output logic              o_l_rvalid,
    output logic [DATA_W-1:0] o_l_rdata,
    output logic              o_m_en,
    output logic              o_m_we,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    input  logic [DATA_W-1:0] i_m_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            r_state;
    state_t            w_next_state;
    owner_t            r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic              r_flushed;
    logic              r_p_rvalid;
    logic              r_l_rvalid;
    logic [DATA_W-1:0] r_p_rdata;
    logic [DATA_W-1:0] r_l_rdata;

    logic              w_arb_en;
    logic              w_win_valid;
    owner_t            w_win_owner;
    logic              w_flush_now;
    logic              w_last_wait;
    logic [DATA_W-1:0] w_load_data;

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_arb_en    (w_arb_en),
        .i_p_req     (i_p_req),
        .i_l_req     (i_l_req),
        .o_win_valid (w_win_valid),
        .o_win_owner (w_win_owner)
    );

    assign w_flush_now = i_p_flush && (r_owner == OWN_P) && (r_state != ST_IDLE);
    assign w_last_wait = (r_state == ST_WAIT) && (r_lat_cnt == '0);
    assign w_load_data = r_we ? '0 : i_m_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_arb_en     = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_arb_en     = 1'b1;
                w_next_state = w_win_valid ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  if (r_lat_cnt == '0) w_next_state = ST_RESP;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, latency countdown and per-port response registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner    <= OWN_P;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lat_cnt  <= '0;
            r_flushed  <= 1'b0;
            r_p_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
            r_p_rdata  <= '0;
            r_l_rdata  <= '0;
        end else begin
            r_p_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
            if (w_arb_en && w_win_valid) begin
                r_owner   <= w_win_owner;
                r_flushed <= 1'b0;
                if (w_win_owner == OWN_P) begin
                    r_we    <= i_p_we;
                    r_addr  <= i_p_addr;
                    r_wdata <= i_p_wdata;
                end else begin
                    r_we    <= i_l_we;
                    r_addr  <= i_l_addr;
                    r_wdata <= i_l_wdata;
                end
            end else if (w_flush_now) begin
                r_flushed <= 1'b1;
            end
            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= CNT_W'(MEM_LAT - 1);
            end else if (r_state == ST_WAIT && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - CNT_W'(1);
            end
            // A flushed P access still hits memory but never updates p_rdata.
            if (w_last_wait) begin
                if (r_owner == OWN_L) begin
                    r_l_rvalid <= 1'b1;
                    r_l_rdata  <= w_load_data;
                end else if (!r_flushed && !w_flush_now) begin
                    r_p_rvalid <= 1'b1;
                    r_p_rdata  <= w_load_data;
                end
            end
        end
    end

    assign o_p_gnt     = (r_state == ST_ISSUE) && (r_owner == OWN_P);
    assign o_l_gnt     = (r_state == ST_ISSUE) && (r_owner == OWN_L);
    assign o_p_rvalid  = r_p_rvalid && !i_p_flush;
    assign o_l_rvalid  = r_l_rvalid;
    assign o_p_rdata   = r_p_rdata;
    assign o_l_rdata   = r_l_rdata;
    assign o_mem_stall = i_p_req && !o_p_rvalid;
    assign o_m_en      = (r_state == ST_ISSUE);
    assign o_m_we      = (r_state == ST_ISSUE) && r_we;
    assign o_m_addr    = r_addr;
    assign o_m_wdata   = r_wdata;

endmodule
